// File: rtl/count_leading_zeros_reg.sv
// Registered leading-zero counter: a log2(WIDTH)-level merge tree computes the
// MSB-first zero run combinationally, and a single register stage captures it.
module count_leading_zeros_reg #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_VALID,
    input  logic [WIDTH-1:0] i_WORD,
    output logic             o_VALID,
    output logic [CW-1:0]    o_COUNT,
    output logic             o_ZERO
);

    localparam int LEVELS = $clog2(WIDTH);

    // Each node holds (all-zero flag, leading-zero count of its slice). A leaf
    // counts 1 for a clear bit, so an all-zero node naturally sums to its size.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = WIDTH >> l;
        logic [N-1:0]  zf;
        logic [CW-1:0] cnt [N];

        if (l == 0) begin : g_leaf
            always_comb begin
                zf = ~i_WORD;
                for (int i = 0; i < N; i++) begin
                    cnt[i] = {{(CW-1){1'b0}}, ~i_WORD[i]};
                end
            end
        end else begin : g_merge
            localparam logic [CW-1:0] HALF = CW'(1 << (l - 1));
            always_comb begin
                for (int n = 0; n < N; n++) begin
                    zf[n]  = g_lvl[l-1].zf[2*n+1] & g_lvl[l-1].zf[2*n];
                    cnt[n] = g_lvl[l-1].zf[2*n+1] ? (HALF + g_lvl[l-1].cnt[2*n])
                                                  : g_lvl[l-1].cnt[2*n+1];
                end
            end
        end
    end

    logic [CW-1:0] count_p0;
    logic          zero_p0;

    assign count_p0 = g_lvl[LEVELS].cnt[0];
    assign zero_p0  = g_lvl[LEVELS].zf[0];

    // Stage p0 -> p1: result register; data only loads on a valid word
    logic          vld_p1;
    logic [CW-1:0] count_p1;
    logic          zero_p1;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            vld_p1   <= 1'b0;
            count_p1 <= '0;
            zero_p1  <= 1'b0;
        end else begin
            vld_p1 <= i_VALID;
            if (i_VALID) begin
                count_p1 <= count_p0;
                zero_p1  <= zero_p0;
            end
        end
    end

    assign o_VALID = vld_p1;
    assign o_COUNT = count_p1;
    assign o_ZERO  = zero_p1;

endmodule

// File: tb/tb_count_leading_zeros_reg.sv
// Self-checking bench for count_leading_zeros_reg: fixed vector table, corner
// sequences (walking one, hold, async reset) and randomized words vs. a model.
module tb_count_leading_zeros_reg;

    localparam int WIDTH = 32;
    localparam int CW    = $clog2(WIDTH) + 1;

    logic             clk;
    logic             rst;
    logic             i_valid;
    logic [WIDTH-1:0] i_word;
    logic             o_valid;
    logic [CW-1:0]    o_count;
    logic             o_zero;

    int checks = 0;
    int errors = 0;

    count_leading_zeros_reg #(.WIDTH(WIDTH)) dut (
        .i_CLK   (clk),
        .i_RST   (rst),
        .i_VALID (i_valid),
        .i_WORD  (i_word),
        .o_VALID (o_valid),
        .o_COUNT (o_count),
        .o_ZERO  (o_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] word;
        int               count;
        logic             zero;
    } vec_t;

    vec_t vecs [8];

    // Reference: scan from the MSB for the first set bit.
    function automatic int clz_ref(input logic [WIDTH-1:0] w);
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (w[k]) return WIDTH - 1 - k;
        end
        return WIDTH;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input int vld, input int cnt, input int zr);
        check({name, ".valid"}, int'(o_valid), vld);
        check({name, ".count"}, int'(o_count), cnt);
        check({name, ".zero"},  int'(o_zero),  zr);
    endtask

    initial begin
        int exp_count;
        int exp_zero;
        logic [WIDTH-1:0] w;
        logic v;

        vecs[0] = '{32'hA000_8A28, 0,  1'b0};
        vecs[1] = '{32'h0000_0000, 32, 1'b1};
        vecs[2] = '{32'h0000_0001, 31, 1'b0};
        vecs[3] = '{32'h0000_FFFF, 16, 1'b0};
        vecs[4] = '{32'h0001_0000, 15, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 1,  1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 0,  1'b0};
        vecs[7] = '{32'h0000_0300, 22, 1'b0};

        rst = 1'b1;
        i_valid = 1'b0;
        i_word = '0;

        @(negedge clk);
        check_out("reset", 0, 0, 0);
        rst = 1'b0;

        // Table vectors, back to back
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            i_word  = vecs[i].word;
            @(negedge clk);
            check_out($sformatf("vec%0d", i), 1, vecs[i].count, int'(vecs[i].zero));
        end

        // Walking one, continuous valid
        for (int k = WIDTH - 1; k >= 0; k--) begin
            i_valid = 1'b1;
            i_word  = WIDTH'(1) << k;
            @(negedge clk);
            check_out($sformatf("walk%0d", k), 1, WIDTH - 1 - k, 0);
        end

        // Async reset between edges while holding count 31
        #2 rst = 1'b1;
        #1 check_out("async_rst", 0, 0, 0);
        i_valid = 1'b1;
        i_word  = 32'h1234_5678;
        @(negedge clk);
        check_out("rst_discard", 0, 0, 0);
        rst = 1'b0;
        i_word = 32'h00F0_0000;
        @(negedge clk);
        check_out("post_rst", 1, 8, 0);

        // Hold with i_VALID low and changing words
        i_word = 32'h0000_0000;
        @(negedge clk);
        check_out("hold_zero_load", 1, 32, 1);
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b0;
            i_word  = $urandom;
            @(negedge clk);
            check_out($sformatf("hold%0d", i), 0, 32, 1);
        end

        // Randomized stream against the reference model
        exp_count = 32;
        exp_zero  = 1;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            w = WIDTH'($urandom) >> $urandom_range(0, WIDTH);
            i_valid = v;
            i_word  = w;
            if (v) begin
                exp_count = clz_ref(w);
                exp_zero  = (w == '0) ? 1 : 0;
            end
            @(negedge clk);
            check_out($sformatf("rand%0d", i), int'(v), exp_count, exp_zero);
        end

        i_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_leading_zeros_reg.md
Name: count_leading_zeros_reg

Overview:
Registered leading-zero counter for a WIDTH-bit word, MSB-first. Used in arithmetic datapaths (normalisation, priority encoding) where the CLZ result must be a registered value. Single pipeline stage with a valid qualifier; fully parallel throughput, one word per cycle.

Parameters:
WIDTH, 32, input word width in bits; must be a power of two, minimum 2.
CW, $clog2(WIDTH)+1 (6 for WIDTH=32), width of the count output; derived, not overridden.

Ports:
i_CLK  input  1  rising-edge clock
i_RST  input  1  reset; asynchronous, active-high
i_VALID  input  1  qualifies i_WORD this cycle
i_WORD  input  WIDTH  word to examine; bit WIDTH-1 is the MSB
o_VALID  output  1  registered i_VALID; o_COUNT/o_ZERO are meaningful when high
o_COUNT  output  CW  number of consecutive 0 bits starting from bit WIDTH-1, range 0..WIDTH
o_ZERO  output  1  high when the captured word was all zeros (o_COUNT==WIDTH)

Behaviour:
- Reset: while i_RST is high, o_VALID=0, o_COUNT=0, o_ZERO=0, independent of clock. First capture occurs on the first rising edge after deassertion.
- Count function: o_COUNT = WIDTH-1-k, where k is the index of the highest set bit of i_WORD. If i_WORD==0, o_COUNT=WIDTH and o_ZERO=1. Otherwise o_ZERO=0.
- Implementation: combinational log2(WIDTH)-level tree. Each level merges the (zero-flag, partial-count) pairs of adjacent halves. If the upper half is all-zero, result = half-size + lower count; else result = upper count. The result is then registered. No priority chains longer than the tree depth.
- Latency: exactly 1 cycle. The word sampled at edge N (with i_VALID=1) produces o_VALID=1 with its count after edge N.
- i_VALID=0 at an edge: o_VALID drops to 0 and o_COUNT/o_ZERO hold their previous values (no update).
- Back-to-back valid words: each edge updates; no bubbles, no stall/backpressure.
- Reset asserted mid-stream: outputs clear immediately. Any word sampled on the same edge as reset is discarded.
- X/undefined i_WORD bits with i_VALID=0 must not propagate into held outputs.
- o_COUNT is unsigned, zero-extended to CW bits. No saturation is needed because the maximum value is WIDTH, which fits in CW.

Test Plan:
- Reset then i_VALID=1, i_WORD=32'hA000_8A28 (MSB set) -> next cycle o_VALID=1, o_COUNT=0, o_ZERO=0.
- i_WORD=32'h0000_0000 -> o_COUNT=32, o_ZERO=1; i_WORD=32'h0000_0001 -> o_COUNT=31, o_ZERO=0.
- Walking one: i_WORD=1<<k for k=31..0 on consecutive cycles -> o_COUNT=31-k each following cycle, o_VALID high continuously.
- Non-leading bits ignored: i_WORD=32'h0000_FFFF -> 16; 32'h0001_0000 -> 15; 32'h7FFF_FFFF -> 1.
- i_VALID=0 with i_WORD changing -> o_VALID=0, o_COUNT/o_ZERO unchanged from last valid result.
- Assert i_RST asynchronously between edges while o_VALID=1, o_COUNT=31 -> outputs go to 0 before the next edge; after release the first valid word gives the correct count one cycle later.
